// File: rtl/serv_ibus_prefetch.sv
// Instruction-bus front end with a one-word PC+4 prefetch buffer toward Wishbone.
// Latency: buffer hit acks 1 cycle after the request, a miss acks 1 cycle after i_wb_ack.
// Backpressure: core holds i_ibus_cyc until o_ibus_ack; one Wishbone read outstanding, never aborted.
module serv_ibus_prefetch #(
    parameter int PREFETCH = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEMAND = 2'd1,
        ST_ACK    = 2'd2,
        ST_PREF   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, ack_d;
    logic [29:0] wb_adr_q, wb_adr_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic [31:0] buf_q, buf_d;
    logic [29:0] tag_q, tag_d;
    logic        buf_valid_q, buf_valid_d;
    logic        stale_q, stale_d;
    logic [29:0] last_adr_q, last_adr_d;

    logic        hit;
    logic        pf_match;
    logic [29:0] next_pc;
    logic        unused_adr_bits;

    // Instructions are word aligned, so the byte offset of the PC carries no information.
    assign unused_adr_bits = ^i_ibus_adr[1:0];

    assign hit      = buf_valid_q & (i_ibus_adr[31:2] == tag_q) & ~i_flush;
    assign pf_match = (i_ibus_adr[31:2] == wb_adr_q);
    // Word-granular increment wraps 0xFFFFFFFC to 0x00000000 for free.
    assign next_pc  = last_adr_q + 30'd1;

    assign o_ibus_rdt = rdt_q;
    assign o_ibus_ack = ack_q;
    assign o_wb_adr   = {wb_adr_q, 2'b00};
    assign o_wb_cyc   = wb_cyc_q;

    // Next-state and registered-output logic for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        rdt_d       = rdt_q;
        ack_d       = 1'b0;
        wb_adr_d    = wb_adr_q;
        wb_cyc_d    = wb_cyc_q;
        buf_d       = buf_q;
        tag_d       = tag_q;
        buf_valid_d = buf_valid_q;
        stale_d     = stale_q;
        last_adr_d  = last_adr_q;

        // A PC redirect invalidates whatever the buffer holds, whatever state we are in.
        if (i_flush) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_ibus_cyc) begin
                    if (hit) begin
                        state_d     = ST_ACK;
                        ack_d       = 1'b1;
                        rdt_d       = buf_q;
                        buf_valid_d = 1'b0;
                        last_adr_d  = i_ibus_adr[31:2];
                    end else begin
                        state_d  = ST_DEMAND;
                        wb_cyc_d = 1'b1;
                        wb_adr_d = i_ibus_adr[31:2];
                    end
                end
            end

            ST_DEMAND: begin
                // The demand address already is the redirected PC, so a flush changes nothing here.
                if (i_wb_ack) begin
                    state_d    = ST_ACK;
                    ack_d      = 1'b1;
                    rdt_d      = i_wb_rdt;
                    wb_cyc_d   = 1'b0;
                    last_adr_d = wb_adr_q;
                end
            end

            ST_ACK: begin
                // The request is complete this cycle; i_ibus_cyc is not looked at.
                if (PREFETCH != 0) begin
                    state_d  = ST_PREF;
                    wb_cyc_d = 1'b1;
                    wb_adr_d = next_pc;
                    stale_d  = i_flush;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PREF: begin
                if (i_flush) begin
                    stale_d = 1'b1;
                end
                if (i_wb_ack) begin
                    wb_cyc_d = 1'b0;
                    stale_d  = 1'b0;
                    if (i_ibus_cyc) begin
                        if (pf_match && !stale_q && !i_flush) begin
                            // Core is already waiting for exactly this word: forward it.
                            state_d    = ST_ACK;
                            ack_d      = 1'b1;
                            rdt_d      = i_wb_rdt;
                            last_adr_d = wb_adr_q;
                        end else begin
                            // Wrong or stale word: drop it and start the demand read back-to-back.
                            state_d  = ST_DEMAND;
                            wb_cyc_d = 1'b1;
                            wb_adr_d = i_ibus_adr[31:2];
                        end
                    end else begin
                        state_d     = ST_IDLE;
                        buf_d       = i_wb_rdt;
                        tag_d       = wb_adr_q;
                        buf_valid_d = ~(stale_q | i_flush);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in progress.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            rdt_q       <= 32'd0;
            ack_q       <= 1'b0;
            wb_adr_q    <= 30'd0;
            wb_cyc_q    <= 1'b0;
            buf_q       <= 32'd0;
            tag_q       <= 30'd0;
            buf_valid_q <= 1'b0;
            stale_q     <= 1'b0;
            last_adr_q  <= 30'd0;
        end else begin
            state_q     <= state_d;
            rdt_q       <= rdt_d;
            ack_q       <= ack_d;
            wb_adr_q    <= wb_adr_d;
            wb_cyc_q    <= wb_cyc_d;
            buf_q       <= buf_d;
            tag_q       <= tag_d;
            buf_valid_q <= buf_valid_d;
            stale_q     <= stale_d;
            last_adr_q  <= last_adr_d;
        end
    end

endmodule
